// File: rtl/udp_gen_pkg.sv
// udp_gen_pkg: shared FSM state encoding and payload mode codes for the UDP tx packet generator.
// Rev 1.0
`default_nettype none

package udp_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/udp_payload_gen.sv
// udp_payload_gen: payload word register with increment / constant / Galois LFSR / walking-one advance.
// Rev 1.0
`default_nettype none

module udp_payload_gen
  import udp_gen_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] INC_STEP  = 32'h0000_1111,
  parameter logic [DATA_W-1:0] SEED      = '0,
  parameter logic [DATA_W-1:0] LFSR_POLY = 32'h8020_0003
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] next_word;

  always_comb begin
    next_word = data;
    case (mode)
      MODE_INC:   next_word = data + INC_STEP;
      MODE_CONST: next_word = data;
      MODE_LFSR:  next_word = data[0] ? ((data >> 1) ^ LFSR_POLY) : (data >> 1);
      // An all-zero word would rotate forever as zero, so it seeds the walking bit.
      MODE_WALK:  next_word = (data == '0) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                           : {data[DATA_W-2:0], data[DATA_W-1]};
      default:    next_word = data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= SEED;
    end else if (advance) begin
      data <= next_word;
    end
  end

endmodule

`default_nettype wire

// File: rtl/udp_tx_pkt_gen.sv
// udp_tx_pkt_gen: programmable UDP transmit packet source with gap control and done-watchdog.
// Rev 1.0
`default_nettype none

module udp_tx_pkt_gen
  import udp_gen_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                LEN_W       = 16,
  parameter int                GAP_W       = 16,
  parameter logic [DATA_W-1:0] INC_STEP    = 32'h0000_1111,
  parameter logic [DATA_W-1:0] SEED        = '0,
  parameter logic [DATA_W-1:0] LFSR_POLY   = 32'h8020_0003,
  parameter int                TIMEOUT_CYC = 65535
) (
  input  logic              gmii_tx_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       pkt_count,
  input  logic [LEN_W-1:0]  len_a,
  input  logic [LEN_W-1:0]  len_b,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [1:0]        mode,
  input  logic              tx_req,
  input  logic              tx_done,
  output logic              tx_start_en,
  output logic [DATA_W-1:0] tx_data,
  output logic [LEN_W-1:0]  tx_byte_num,
  output logic              busy,
  output logic [15:0]       pkts_sent,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_next;
  logic              stop_q;
  logic              idx;
  logic [15:0]       pkt_cnt_q;
  logic [LEN_W-1:0]  len_a_q, len_b_q;
  logic [GAP_W-1:0]  gap_q, gap_cnt;
  logic [1:0]        mode_q;
  logic [WD_W-1:0]   wd_cnt;

  logic              stop_any, done_last, wd_expire, gap_expire;
  logic              pl_load, pl_advance;
  logic [1:0]        pl_mode;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : l;
  endfunction

  assign stop_any   = stop | stop_q;
  assign done_last  = (pkt_cnt_q != 16'd0) && ((pkts_sent + 16'd1) == pkt_cnt_q);
  assign wd_expire  = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign gap_expire = (gap_cnt == (gap_q - 1'b1));

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    tx_start_en = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_ARM;
      ST_ARM: begin
        tx_start_en = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (stop_any || done_last) state_next = ST_IDLE;
          else if (gap_q == '0)      state_next = ST_ARM;
          else                       state_next = ST_GAP;
        end else if (wd_expire) begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (stop_any)        state_next = ST_IDLE;
        else if (gap_expire) state_next = ST_ARM;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Done reloads the seed, so a coincident tx_req must not also advance the word.
  assign pl_load    = ((state == ST_IDLE) && start) || ((state == ST_WAIT) && tx_done);
  assign pl_advance = (state == ST_WAIT) && tx_req && !tx_done;
  assign pl_mode    = (state == ST_IDLE) ? mode : mode_q;

  udp_payload_gen #(
    .DATA_W    (DATA_W),
    .INC_STEP  (INC_STEP),
    .SEED      (SEED),
    .LFSR_POLY (LFSR_POLY)
  ) u_payload (
    .clk     (gmii_tx_clk),
    .rst     (rst),
    .load    (pl_load),
    .advance (pl_advance),
    .mode    (pl_mode),
    .data    (tx_data)
  );

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      stop_q      <= 1'b0;
      idx         <= 1'b0;
      pkt_cnt_q   <= '0;
      len_a_q     <= '0;
      len_b_q     <= '0;
      gap_q       <= '0;
      mode_q      <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      tx_byte_num <= '0;
      busy        <= 1'b0;
      pkts_sent   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_next == ST_IDLE) stop_q <= 1'b0;
      else if (stop)             stop_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            pkt_cnt_q   <= pkt_count;
            len_a_q     <= len_a;
            len_b_q     <= len_b;
            gap_q       <= gap_cycles;
            mode_q      <= mode;
            idx         <= 1'b0;
            pkts_sent   <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            tx_byte_num <= clamp_len(len_a);
          end
        end
        ST_ARM: wd_cnt <= '0;
        ST_WAIT: begin
          if (tx_done) begin
            pkts_sent <= pkts_sent + 16'd1;
            idx       <= ~idx;
            gap_cnt   <= '0;
            if (state_next == ST_IDLE) busy <= 1'b0;
            // idx has not toggled yet, so the next packet uses the opposite length.
            if (state_next == ST_ARM) tx_byte_num <= clamp_len(idx ? len_a_q : len_b_q);
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire) begin
              err_timeout <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (state_next == ST_IDLE) busy <= 1'b0;
          if (state_next == ST_ARM)  tx_byte_num <= clamp_len(idx ? len_b_q : len_a_q);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_pkt_gen.sv
// tb_udp_tx_pkt_gen: directed self-checking bench for udp_tx_pkt_gen (SEED=0 and SEED=1 instances).
// Rev 1.0
`default_nettype none

module tb_udp_tx_pkt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pkt_count = '0;
  logic [15:0] len_a = '0;
  logic [15:0] len_b = '0;
  logic [15:0] gap_cycles = '0;
  logic [1:0]  mode = '0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;

  logic        tx_start_en, busy, err_timeout;
  logic [31:0] tx_data;
  logic [15:0] tx_byte_num, pkts_sent;

  logic        l_tx_start_en, l_busy, l_err_timeout;
  logic [31:0] l_tx_data;
  logic [15:0] l_tx_byte_num, l_pkts_sent;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  udp_tx_pkt_gen #(.SEED(32'd0), .TIMEOUT_CYC(50)) dut (
    .gmii_tx_clk(clk), .rst(rst), .start(start), .stop(stop), .pkt_count(pkt_count),
    .len_a(len_a), .len_b(len_b), .gap_cycles(gap_cycles), .mode(mode),
    .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(tx_start_en), .tx_data(tx_data),
    .tx_byte_num(tx_byte_num), .busy(busy), .pkts_sent(pkts_sent), .err_timeout(err_timeout)
  );

  udp_tx_pkt_gen #(.SEED(32'd1), .TIMEOUT_CYC(50)) dut_l (
    .gmii_tx_clk(clk), .rst(rst), .start(start), .stop(stop), .pkt_count(pkt_count),
    .len_a(len_a), .len_b(len_b), .gap_cycles(gap_cycles), .mode(mode),
    .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(l_tx_start_en), .tx_data(l_tx_data),
    .tx_byte_num(l_tx_byte_num), .busy(l_busy), .pkts_sent(l_pkts_sent), .err_timeout(l_err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serves nwords tx_req beats checking an incrementing payload, then pulses tx_done.
  task automatic serve(input int nwords, input logic [31:0] inc, input string tag);
    for (int i = 0; i < nwords; i++) begin
      chk(tag, tx_data, i * inc);
      tx_req = 1'b1;
      step();
      tx_req = 1'b0;
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!tx_start_en && n < 2000) begin
      step();
      n++;
    end
    chk("start_seen", {31'd0, n < 2000}, 32'd1);
  endtask

  task automatic go(input logic [15:0] pc, input logic [15:0] la, input logic [15:0] lb,
                    input logic [15:0] gp, input logic [1:0] md);
    pkt_count = pc; len_a = la; len_b = lb; gap_cycles = gp; mode = md;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int pulses;

    step(); step();
    rst = 1'b0;
    step();
    chk("rst_start_en", {31'd0, tx_start_en}, 32'd0);
    chk("rst_data", tx_data, 32'd0);
    chk("rst_byte_num", {16'd0, tx_byte_num}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pkts", {16'd0, pkts_sent}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);

    // 1: two packets, alternating lengths, incrementing payload, gap 100
    go(16'd2, 16'd10, 16'd30, 16'd100, 2'd0);
    chk("t1_latency", {31'd0, tx_start_en}, 32'd1);
    chk("t1_len_a", {16'd0, tx_byte_num}, 32'd10);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t1_start_once", {31'd0, tx_start_en}, 32'd0);
    serve(3, 32'h1111, "t1_p0_data");
    chk("t1_pkts1", {16'd0, pkts_sent}, 32'd1);
    chk("t1_reload", tx_data, 32'd0);
    wait_start(n);
    chk("t1_gap", n, 32'd100);
    chk("t1_len_b", {16'd0, tx_byte_num}, 32'd30);
    step();
    serve(8, 32'h1111, "t1_p1_data");
    chk("t1_pkts2", {16'd0, pkts_sent}, 32'd2);
    chk("t1_busy_fall", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_start_en) pulses++;
      step();
    end
    chk("t1_no_more", pulses, 32'd0);

    // 2: Galois LFSR from SEED=1 (second instance)
    go(16'd1, 16'd12, 16'd12, 16'd0, 2'd2);
    step();
    chk("t2_w0", l_tx_data, 32'h0000_0001);
    tx_req = 1'b1;
    step();
    chk("t2_w1", l_tx_data, 32'h8020_0003);
    step();
    chk("t2_w2", l_tx_data, 32'hC030_0002);
    step();
    chk("t2_w3", l_tx_data, 32'h6018_0001);
    tx_req = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t2_reload", l_tx_data, 32'h0000_0001);
    chk("t2_idle", {31'd0, l_busy}, 32'd0);

    // 3: tx_req coincident with tx_done
    go(16'd1, 16'd8, 16'd8, 16'd0, 2'd0);
    step();
    tx_req = 1'b1;
    step();
    chk("t3_adv", tx_data, 32'h1111);
    tx_done = 1'b1;
    step();
    tx_req = 1'b0;
    tx_done = 1'b0;
    chk("t3_seed", tx_data, 32'd0);
    chk("t3_pkts", {16'd0, pkts_sent}, 32'd1);
    step();
    chk("t3_hold", tx_data, 32'd0);

    // 4: continuous run, stop during the third packet's WAIT
    go(16'd0, 16'd4, 16'd4, 16'd2, 2'd0);
    for (int p = 0; p < 2; p++) begin
      wait_start(n);
      step();
      serve(1, 32'h1111, "t4_data");
    end
    wait_start(n);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    serve(1, 32'h1111, "t4_last_data");
    chk("t4_pkts", {16'd0, pkts_sent}, 32'd3);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_start_en) pulses++;
      step();
    end
    chk("t4_no_more", pulses, 32'd0);

    // 5: watchdog with no tx_done
    go(16'd1, 16'd4, 16'd4, 16'd0, 2'd0);
    chk("t5_arm", {31'd0, tx_start_en}, 32'd1);
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
    end
    chk("t5_cycles", n, 32'd51);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_pkts", {16'd0, pkts_sent}, 32'd0);
    go(16'd1, 16'd4, 16'd4, 16'd0, 2'd0);
    chk("t5_err_clear", {31'd0, err_timeout}, 32'd0);
    chk("t5_rebusy", {31'd0, busy}, 32'd1);
    step();
    serve(1, 32'h1111, "t5_data");

    // 6a: len_a=0 clamps to 1; start while busy is ignored
    go(16'd1, 16'd0, 16'd4, 16'd0, 2'd0);
    chk("t6_len_clamp", {16'd0, tx_byte_num}, 32'd1);
    step();
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_ign_data", tx_data, 32'h1111);
    chk("t6_ign_start", {31'd0, tx_start_en}, 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t6_ign_idle", {31'd0, busy}, 32'd0);
    step();
    chk("t6_ign_nostart", {31'd0, tx_start_en}, 32'd0);

    // 6b: reset during WAIT
    go(16'd1, 16'd8, 16'd8, 16'd0, 2'd0);
    step();
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
    rst = 1'b1;
    step();
    chk("t6_rst_start_en", {31'd0, tx_start_en}, 32'd0);
    chk("t6_rst_data", tx_data, 32'd0);
    chk("t6_rst_byte_num", {16'd0, tx_byte_num}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_pkts", {16'd0, pkts_sent}, 32'd0);
    chk("t6_rst_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
